// File: rtl/dram_cmd_issuer_if.sv
// rtl/dram_cmd_issuer_if.sv - request, DDR4 command and completion bundle for dram_cmd_issuer
interface dram_cmd_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [32:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        resp_valid;
  logic        resp_err;
  logic [1:0]  resp_op;
  logic [32:0] resp_addr;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  resp_valid, resp_err, resp_op, resp_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output resp_valid, resp_err, resp_op, resp_addr
  );
endinterface

// File: rtl/dram_cmd_issuer.sv
// rtl/dram_cmd_issuer.sv - in-order open-page DDR4 PRE/ACT/RD/WR issuer, one request at a time
module dram_cmd_issuer #(
  parameter int TRCD   = 24,
  parameter int TRP    = 24,
  parameter int TRAS   = 52,
  parameter int TCL    = 24,
  parameter int TCWL   = 20,
  parameter int TBURST = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  dram_cmd_issuer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_ACT, S_RW, S_DONE
  } state_t;

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  // Counters load T-1 so the dependent command lands exactly T cycles later.
  localparam logic [8:0] L_TRCD = 9'(TRCD - 1);
  localparam logic [8:0] L_TRP  = 9'(TRP - 1);
  localparam logic [8:0] L_RD   = 9'(TCL + TBURST - 1);
  localparam logic [8:0] L_WR   = 9'(TCWL + TBURST - 1);
  localparam logic [7:0] L_TRAS = 8'(TRAS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [32:0] r_addr;
  logic [8:0]  r_timer;
  logic [7:0]  r_tras [16];
  logic [15:0] r_open;
  logic [14:0] r_open_row [16];
  logic        r_req_ready;
  logic [1:0]  r_resp_op;
  logic [32:0] r_resp_addr;

  logic [14:0] w_row;
  logic [10:0] w_col;
  logic [1:0]  w_bg;
  logic [1:0]  w_ba;
  logic [3:0]  w_bank;
  logic        w_accept;
  logic        w_cmd_valid;
  logic [2:0]  w_cmd;
  logic [14:0] w_cmd_row;
  logic [10:0] w_cmd_col;
  logic        w_resp;
  logic        w_load_timer;
  logic [8:0]  w_timer_val;
  logic        w_do_pre;
  logic        w_do_act;

  assign w_row    = r_addr[32:18];
  assign w_col    = {r_addr[17:10], r_addr[5:3]};
  assign w_ba     = r_addr[9:8];
  assign w_bg     = r_addr[7:6];
  assign w_bank   = {w_bg, w_ba};
  assign w_accept = (r_state == S_IDLE) && bus.req_valid && r_req_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_valid  = 1'b0;
    w_cmd        = 3'd0;
    w_cmd_row    = 15'd0;
    w_cmd_col    = 11'd0;
    w_resp       = 1'b0;
    w_load_timer = 1'b0;
    w_timer_val  = 9'd0;
    w_do_pre     = 1'b0;
    w_do_act     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (r_op == 2'd3)                                         w_state_nxt = S_DONE;
        else if (r_open[w_bank] && (r_open_row[w_bank] == w_row)) w_state_nxt = S_RW;
        else if (r_open[w_bank])                                  w_state_nxt = S_PRE;
        else                                                      w_state_nxt = S_ACT;
      end
      S_PRE: begin
        if (r_tras[w_bank] == 8'd0) begin
          w_cmd_valid  = 1'b1;
          w_cmd        = CMD_PRE;
          w_do_pre     = 1'b1;
          w_load_timer = 1'b1;
          w_timer_val  = L_TRP;
          w_state_nxt  = S_ACT;
        end
      end
      S_ACT: begin
        if (r_timer == 9'd0) begin
          w_cmd_valid  = 1'b1;
          w_cmd        = CMD_ACT;
          w_cmd_row    = w_row;
          w_do_act     = 1'b1;
          w_load_timer = 1'b1;
          w_timer_val  = L_TRCD;
          w_state_nxt  = S_RW;
        end
      end
      S_RW: begin
        if (r_timer == 9'd0) begin
          w_cmd_valid  = 1'b1;
          w_cmd        = (r_op == 2'd1) ? CMD_WR : CMD_RD;
          w_cmd_col    = w_col;
          w_load_timer = 1'b1;
          w_timer_val  = (r_op == 2'd1) ? L_WR : L_RD;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (r_timer == 9'd0) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_addr      <= 33'd0;
      r_timer     <= 9'd0;
      r_open      <= 16'd0;
      r_req_ready <= 1'b0;
      r_resp_op   <= 2'd0;
      r_resp_addr <= 33'd0;
      for (int i = 0; i < 16; i++) begin
        r_tras[i]     <= 8'd0;
        r_open_row[i] <= 15'd0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_op   <= bus.req_op;
        r_addr <= bus.req_addr;
      end
      if (w_load_timer)          r_timer <= w_timer_val;
      else if (r_timer != 9'd0)  r_timer <= r_timer - 9'd1;
      if (w_do_pre) r_open[w_bank] <= 1'b0;
      if (w_do_act) begin
        r_open[w_bank]     <= 1'b1;
        r_open_row[w_bank] <= w_row;
      end
      // tRAS counters run for every bank, not just the one being served.
      for (int i = 0; i < 16; i++) begin
        if (w_do_act && (4'(i) == w_bank)) r_tras[i] <= L_TRAS;
        else if (r_tras[i] != 8'd0)        r_tras[i] <= r_tras[i] - 8'd1;
      end
      if (w_resp) begin
        r_resp_op   <= r_op;
        r_resp_addr <= r_addr;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.cmd_valid  = w_cmd_valid;
  assign bus.cmd        = w_cmd;
  assign bus.cmd_bg     = w_cmd_valid ? w_bg : 2'd0;
  assign bus.cmd_ba     = w_cmd_valid ? w_ba : 2'd0;
  assign bus.cmd_row    = w_cmd_row;
  assign bus.cmd_col    = w_cmd_col;
  assign bus.resp_valid = w_resp;
  assign bus.resp_err   = w_resp && (r_op == 2'd3);
  assign bus.resp_op    = w_resp ? r_op   : r_resp_op;
  assign bus.resp_addr  = w_resp ? r_addr : r_resp_addr;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb/tb_dram_cmd_issuer.sv - directed checks of dram_cmd_issuer command timing and bank state
module tb_dram_cmd_issuer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dram_cmd_issuer_if bus ();

  dram_cmd_issuer u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Command / response log, sampled on the falling edge.
  int          m_cyc [64];
  logic [2:0]  m_cmd [64];
  logic [1:0]  m_bg  [64];
  logic [1:0]  m_ba  [64];
  logic [14:0] m_row [64];
  logic [10:0] m_col [64];
  int          n_cmd = 0;
  int          n_resp = 0;
  int          r_cyc = 0;
  logic        r_err = 1'b0;
  logic [1:0]  r_op = 2'd0;
  logic [32:0] r_addr = 33'd0;
  int          bad_idle = 0;

  always @(negedge clock) begin
    if (bus.cmd_valid) begin
      if (n_cmd < 64) begin
        m_cyc[n_cmd] <= cyc;
        m_cmd[n_cmd] <= bus.cmd;
        m_bg[n_cmd]  <= bus.cmd_bg;
        m_ba[n_cmd]  <= bus.cmd_ba;
        m_row[n_cmd] <= bus.cmd_row;
        m_col[n_cmd] <= bus.cmd_col;
      end
      n_cmd <= n_cmd + 1;
    end else if ((bus.cmd != 3'd0) || (bus.cmd_bg != 2'd0) || (bus.cmd_ba != 2'd0) ||
                 (bus.cmd_row != 15'd0) || (bus.cmd_col != 11'd0)) begin
      bad_idle <= bad_idle + 1;
    end
    if (bus.resp_valid) begin
      n_resp <= n_resp + 1;
      r_cyc  <= cyc;
      r_err  <= bus.resp_err;
      r_op   <= bus.resp_op;
      r_addr <= bus.resp_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [32:0] addr, output int a);
    bit done = 0;
    a = -1;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    for (int k = 0; k < 20 && !done; k++) begin
      if (bus.req_ready) begin
        a = cyc;
        done = 1;
      end else begin
        @(negedge clock);
      end
    end
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_resp(input int base);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      #1;
      if (n_resp > base) done = 1;
    end
    if (!done) check("resp_timeout", 0, 1);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [32:0] addr, output int a, output int cb);
    int rb;
    cb = n_cmd;
    rb = n_resp;
    issue(op, addr, a);
    wait_resp(rb);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int a, a2, cb, cb2, rb, rsp1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_addr  = 33'd0;

    // Reset held for three cycles with a request pending.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("reset_outputs",
            {bus.req_ready, bus.cmd_valid, bus.resp_valid, bus.resp_err, bus.resp_op, bus.resp_addr},
            '0);
    end
    reset_n = 1'b1;
    bus.req_valid = 1'b0;
    #1 check("ready_at_release", bus.req_ready, 0);
    @(negedge clock);
    check("ready_after_release", bus.req_ready, 1);
    check("no_cmd_in_reset", n_cmd, 0);

    // Cold read to bank 0 row 0.
    run_req(2'd0, 33'h0, a, cb);
    check("cold_ncmd", n_cmd - cb, 2);
    check("cold_act", {m_cmd[cb], m_bg[cb], m_ba[cb], m_row[cb]}, {3'd1, 2'd0, 2'd0, 15'd0});
    check("cold_act_t", m_cyc[cb] - a, 2);
    check("cold_rd", {m_cmd[cb+1], m_col[cb+1], m_row[cb+1]}, {3'd3, 11'd0, 15'd0});
    check("cold_rd_t", m_cyc[cb+1] - a, 26);
    check("cold_resp_t", r_cyc - a, 54);
    check("cold_resp", {r_err, r_op, r_addr}, {1'b0, 2'd0, 33'h0});

    // Row hit: col = {addr[17:10], addr[5:3]} = {8'h01, 3'b001}.
    run_req(2'd0, 33'h408, a, cb);
    check("hit_ncmd", n_cmd - cb, 1);
    check("hit_rd", {m_cmd[cb], m_bg[cb], m_ba[cb], m_col[cb]}, {3'd3, 2'd0, 2'd0, 11'h009});
    check("hit_rd_t", m_cyc[cb] - a, 2);
    check("hit_resp_t", r_cyc - a, 30);
    check("hit_resp_addr", r_addr, 33'h408);

    // tRAS-limited precharge on a fresh device.
    do_reset();
    run_req(2'd1, 33'h0, a, cb);
    rsp1 = r_cyc;
    check("wr_act_t", m_cyc[cb] - a, 2);
    check("wr_wr", {m_cmd[cb+1], m_cyc[cb+1] - a}, {3'd4, 32'd26});
    check("wr_resp_t", r_cyc - a, 50);
    run_req(2'd1, 33'h0_0004_0000, a2, cb2);
    check("next_accept", a2 - rsp1, 1);
    check("cf_ncmd", n_cmd - cb2, 3);
    check("cf_pre", {m_cmd[cb2], m_cyc[cb2] - a2}, {3'd2, 32'd3});
    check("cf_pre_tras", m_cyc[cb2] - m_cyc[cb], 52);
    check("cf_act", {m_cmd[cb2+1], m_row[cb2+1], m_cyc[cb2+1] - a2}, {3'd1, 15'd1, 32'd27});
    check("cf_wr", {m_cmd[cb2+2], m_cyc[cb2+2] - a2}, {3'd4, 32'd51});
    check("cf_resp_t", r_cyc - a2, 75);

    // Bank independence: bg1 ba2 row5, then bg1 ba3 row7, then hit on the first.
    run_req(2'd0, 33'h0_0014_0240, a, cb);
    check("bi1", {n_cmd - cb, 32'(m_cmd[cb]), m_bg[cb], m_ba[cb], m_row[cb]},
          {32'd2, 32'd1, 2'd1, 2'd2, 15'd5});
    run_req(2'd1, 33'h0_001C_0340, a, cb);
    check("bi2", {n_cmd - cb, 32'(m_cmd[cb]), m_bg[cb], m_ba[cb], m_row[cb]},
          {32'd2, 32'd1, 2'd1, 2'd3, 15'd7});
    run_req(2'd2, 33'h0_0014_0240, a, cb);
    check("bi3", {n_cmd - cb, 32'(m_cmd[cb]), m_bg[cb], m_ba[cb]}, {32'd1, 32'd3, 2'd1, 2'd2});
    check("bi3_resp", {r_err, r_op, r_cyc - a}, {1'b0, 2'd2, 32'd30});

    // Illegal op: no command, error completion two cycles after accept.
    run_req(2'd3, 33'h123, a, cb);
    check("ill_ncmd", n_cmd - cb, 0);
    check("ill_resp", {r_err, r_op, r_addr, r_cyc - a}, {1'b1, 2'd3, 33'h123, 32'd2});
    @(negedge clock);
    check("resp_hold", {bus.resp_valid, bus.resp_err, bus.resp_op, bus.resp_addr},
          {1'b0, 1'b0, 2'd3, 33'h123});

    // Reset while waiting out tRCD on a miss to bg2 ba1 row3.
    cb = n_cmd;
    rb = n_resp;
    issue(2'd0, 33'h0_000C_0180, a);
    for (int k = 0; k < 20 && n_cmd == cb; k++) @(negedge clock);
    check("mid_act_seen", n_cmd - cb, 1);
    repeat (5) @(negedge clock);
    do_reset();
    repeat (80) @(negedge clock);
    check("mid_no_resp", n_resp - rb, 0);
    check("mid_no_rd", n_cmd - cb, 1);
    run_req(2'd0, 33'h0_000C_0180, a, cb);
    check("post_reset_miss", {n_cmd - cb, 32'(m_cmd[cb]), m_bg[cb], m_ba[cb], m_row[cb]},
          {32'd2, 32'd1, 2'd2, 2'd1, 15'd3});

    check("idle_fields_zero", bad_idle, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
